// File: rtl/rvvi_frame_fifo.sv
// rvvi_frame_fifo: store-and-forward frame buffer from the RVVI packetizer (AXI4 W channel)
// to the Ethernet MAC TX input. A frame is released only once its last word is stored,
// so the MAC never sees a mid-frame underrun while the packetizer stalls. A frame larger
// than the buffer falls back to cut-through and raises a sticky OversizeErr.
//
// Ports
//   clk, resetn                      clock, asynchronous active-low reset
//   SAxiWdata/strb/last/valid/ready  input word stream from the packetizer
//   MAxiWdata/strb/last/valid/ready  output word stream to the MAC (first-word fall-through)
//   Occupancy                        words currently stored, 0..DEPTH_WORDS
//   FramesStored                     complete frames not yet fully read (saturating)
//   OversizeErr                      sticky: counter saturated or cut-through was used
module rvvi_frame_fifo #(
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned FRAME_CNT_W = 8
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [31:0]                    SAxiWdata,
  input  logic [3:0]                     SAxiWstrb,
  input  logic                           SAxiWlast,
  input  logic                           SAxiWvalid,
  output logic                           SAxiWready,
  output logic [31:0]                    MAxiWdata,
  output logic [3:0]                     MAxiWstrb,
  output logic                           MAxiWlast,
  output logic                           MAxiWvalid,
  input  logic                           MAxiWready,
  output logic [$clog2(DEPTH_WORDS):0]   Occupancy,
  output logic [FRAME_CNT_W-1:0]         FramesStored,
  output logic                           OversizeErr
);

  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);
  localparam int unsigned OCC_W  = ADDR_W + 1;

  localparam logic [OCC_W-1:0]       OCC_FULL  = OCC_W'(DEPTH_WORDS);
  localparam logic [OCC_W-1:0]       OCC_ONE   = OCC_W'(1);
  localparam logic [FRAME_CNT_W-1:0] FRAME_ONE = FRAME_CNT_W'(1);
  localparam logic [FRAME_CNT_W-1:0] FRAME_MAX = {FRAME_CNT_W{1'b1}};

  // One stored beat: last flag, byte strobes and data word.
  typedef struct packed {
    logic        last;
    logic [3:0]  strb;
    logic [31:0] data;
  } wordT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CUT  = 2'd2
  } stateT;

  wordT               mem [DEPTH_WORDS];
  wordT               rdWord;
  logic [ADDR_W-1:0]  wrPtr;
  logic [ADDR_W-1:0]  rdPtr;
  stateT              state;
  stateT              nextState;

  logic wrEn;
  logic rdEn;
  logic frameIn;
  logic frameOut;
  logic cutEntry;
  logic satReach;

  // Input side handshake; ready depends on registered occupancy only.
  always_comb begin
    SAxiWready = (Occupancy != OCC_FULL);
    wrEn       = SAxiWvalid & SAxiWready;
    frameIn    = wrEn & SAxiWlast;
  end

  // Output side handshake.
  always_comb begin
    rdEn     = MAxiWvalid & MAxiWready;
    frameOut = rdEn & MAxiWlast;
  end

  // Storage array; no reset needed, contents are qualified by occupancy.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrPtr] <= '{last: SAxiWlast, strb: SAxiWstrb, data: SAxiWdata};
    end
  end

  // Fall-through read of the head word.
  always_comb begin
    rdWord    = mem[rdPtr];
    MAxiWdata = rdWord.data;
    MAxiWstrb = rdWord.strb;
    MAxiWlast = rdWord.last;
  end

  // Pointers wrap naturally because DEPTH_WORDS is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + ADDR_W'(1);
      if (rdEn) rdPtr <= rdPtr + ADDR_W'(1);
    end
  end

  // Word occupancy, 0..DEPTH_WORDS.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      Occupancy <= '0;
    end else begin
      unique case ({wrEn, rdEn})
        2'b10:   Occupancy <= Occupancy + OCC_ONE;
        2'b01:   Occupancy <= Occupancy - OCC_ONE;
        default: Occupancy <= Occupancy;
      endcase
    end
  end

  // Complete-frame counter; saturates instead of wrapping.
  always_comb begin
    satReach = frameIn & ~frameOut & (FramesStored == (FRAME_MAX - FRAME_ONE));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      FramesStored <= '0;
    end else if (frameIn && !frameOut) begin
      if (FramesStored != FRAME_MAX) FramesStored <= FramesStored + FRAME_ONE;
    end else if (frameOut && !frameIn) begin
      if (FramesStored != '0) FramesStored <= FramesStored - FRAME_ONE;
    end
  end

  // Sticky error: counter saturation or fallback to cut-through.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      OversizeErr <= 1'b0;
    end else if (satReach || cutEntry) begin
      OversizeErr <= 1'b1;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Read FSM next state. A full buffer with no complete frame means the
  // current frame can never fit, so it is streamed out cut-through.
  always_comb begin
    nextState = state;
    cutEntry  = 1'b0;
    unique case (state)
      IDLE: begin
        if (FramesStored != '0) begin
          nextState = SEND;
        end else if (Occupancy == OCC_FULL) begin
          nextState = CUT;
          cutEntry  = 1'b1;
        end
      end
      SEND: if (frameOut) nextState = IDLE;
      CUT:  if (frameOut) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Read FSM outputs. In SEND the head frame is complete, so valid holds
  // until its last word; in CUT valid may drop when the buffer runs dry.
  always_comb begin
    MAxiWvalid = 1'b0;
    unique case (state)
      SEND, CUT: MAxiWvalid = (Occupancy != '0);
      default:   MAxiWvalid = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_rvvi_frame_fifo.sv
module tb_rvvi_frame_fifo;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned FCW   = 4;
  localparam int unsigned OW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          resetn;
  logic [31:0]   SAxiWdata;
  logic [3:0]    SAxiWstrb;
  logic          SAxiWlast;
  logic          SAxiWvalid;
  logic          SAxiWready;
  logic [31:0]   MAxiWdata;
  logic [3:0]    MAxiWstrb;
  logic          MAxiWlast;
  logic          MAxiWvalid;
  logic          MAxiWready;
  logic [OW-1:0] Occupancy;
  logic [FCW-1:0] FramesStored;
  logic          OversizeErr;

  int errors = 0;
  int checks = 0;
  int popCount = 0;
  bit holdPending = 0;
  bit sawFull = 0;
  bit done = 0;
  logic [36:0] sbQ[$];
  logic [36:0] expWord;

  rvvi_frame_fifo #(.DEPTH_WORDS(DEPTH), .FRAME_CNT_W(FCW)) dut (
    .clk(clk), .resetn(resetn),
    .SAxiWdata(SAxiWdata), .SAxiWstrb(SAxiWstrb), .SAxiWlast(SAxiWlast),
    .SAxiWvalid(SAxiWvalid), .SAxiWready(SAxiWready),
    .MAxiWdata(MAxiWdata), .MAxiWstrb(MAxiWstrb), .MAxiWlast(MAxiWlast),
    .MAxiWvalid(MAxiWvalid), .MAxiWready(MAxiWready),
    .Occupancy(Occupancy), .FramesStored(FramesStored), .OversizeErr(OversizeErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Scoreboard: accepted input words pushed, output words popped and compared.
  always @(negedge clk) begin
    if (resetn) begin
      if (MAxiWvalid && MAxiWready) begin
        checks++;
        popCount++;
        if (sbQ.size() == 0) begin
          errors++;
          $display("FAIL sb_extra_word got=%h exp=none", {MAxiWlast, MAxiWstrb, MAxiWdata});
        end else begin
          expWord = sbQ.pop_front();
          if ({MAxiWlast, MAxiWstrb, MAxiWdata} !== expWord) begin
            errors++;
            $display("FAIL sb_word got=%h exp=%h", {MAxiWlast, MAxiWstrb, MAxiWdata}, expWord);
          end
        end
      end
      if (holdPending && !dut.cutEntry && dut.state != 2'd2) begin
        checks++;
        if (MAxiWvalid !== 1'b1) begin
          errors++;
          $display("FAIL valid_hold got=%b exp=1", MAxiWvalid);
        end
      end
      holdPending = MAxiWvalid && !(MAxiWready && MAxiWlast);
      if (Occupancy == OW'(DEPTH)) sawFull = 1;
      if (SAxiWvalid && SAxiWready) sbQ.push_back({SAxiWlast, SAxiWstrb, SAxiWdata});
    end else begin
      holdPending = 0;
    end
  end

  // Present one word at posedge+1; returns at posedge+1 after it was accepted.
  task automatic put(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n = 0;
    SAxiWdata = d; SAxiWstrb = s; SAxiWlast = l; SAxiWvalid = 1'b1;
    @(negedge clk);
    while (!SAxiWready && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      errors++; checks++;
      $display("FAIL put_timeout got=stalled exp=accept");
    end
    @(posedge clk); #1;
    SAxiWvalid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((sbQ.size() != 0 || Occupancy != 0) && n < 5000) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL drain_timeout got=occ%0d/q%0d exp=0/0", Occupancy, sbQ.size());
    end
  endtask

  task automatic applyReset();
    SAxiWvalid = 1'b0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    sbQ.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; SAxiWvalid = 1'b0; MAxiWready = 1'b0;
    SAxiWdata = '0; SAxiWstrb = '0; SAxiWlast = 1'b0;
    #12;
    checks++;
    if ({MAxiWvalid, Occupancy, FramesStored, OversizeErr} !== '0) begin
      errors++;
      $display("FAIL reset_state got=v%b o%0d f%0d e%b exp=0", MAxiWvalid, Occupancy, FramesStored, OversizeErr);
    end
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (SAxiWready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", SAxiWready); end
  endtask

  task automatic test_single_frame();
    logic [31:0] w [4];
    int p0 = popCount;
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;
    MAxiWready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (MAxiWvalid !== 1'b0) begin errors++; $display("FAIL early_valid got=%b exp=0 word=%0d", MAxiWvalid, i); end
      put(w[i], 4'hF, i == 3);
    end
    checks++;
    if (FramesStored !== FCW'(1) || MAxiWvalid !== 1'b0) begin
      errors++;
      $display("FAIL commit_latency got=f%0d v%b exp=f1 v0", FramesStored, MAxiWvalid);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (MAxiWvalid !== 1'b1 || MAxiWdata !== w[i] || MAxiWlast !== (i == 3)) begin
        errors++;
        $display("FAIL single_beat%0d got=v%b d%h l%b exp=v1 d%h l%b", i, MAxiWvalid, MAxiWdata, MAxiWlast, w[i], i == 3);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (FramesStored !== '0 || MAxiWvalid !== 1'b0 || popCount - p0 != 4) begin
      errors++;
      $display("FAIL single_end got=f%0d v%b n%0d exp=f0 v0 n4", FramesStored, MAxiWvalid, popCount - p0);
    end
  endtask

  task automatic test_partial_hold();
    int p0 = popCount;
    int bad = 0;
    MAxiWready = 1'b1;
    for (int i = 0; i < 3; i++) put(32'hA0 + 32'(i), 4'h3, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (MAxiWvalid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || Occupancy !== OW'(3)) begin
      errors++;
      $display("FAIL partial_hold got=bad%0d occ%0d exp=bad0 occ3", bad, Occupancy);
    end
    put(32'hA3, 4'hC, 1'b1);
    waitDrain();
    checks++;
    if (popCount - p0 != 4) begin errors++; $display("FAIL partial_emit got=%0d exp=4", popCount - p0); end
  endtask

  task automatic test_fill_full();
    int v = 0;
    int idle = 0;
    int n = 0;
    MAxiWready = 1'b0;
    for (int f = 0; f < 8; f++)
      for (int w = 0; w < 8; w++) put(32'(f * 16 + w), 4'($urandom_range(0, 15)), w == 7);
    checks++;
    if (SAxiWready !== 1'b0 || Occupancy !== OW'(DEPTH) || FramesStored !== FCW'(8)) begin
      errors++;
      $display("FAIL fill_full got=r%b o%0d f%0d exp=r0 o%0d f8", SAxiWready, Occupancy, FramesStored, DEPTH);
    end
    MAxiWready = 1'b1;
    @(posedge clk); #1 MAxiWready = 1'b0;
    checks++;
    if (SAxiWready !== 1'b1 || Occupancy !== OW'(DEPTH - 1)) begin
      errors++;
      $display("FAIL full_release got=r%b o%0d exp=r1 o%0d", SAxiWready, Occupancy, DEPTH - 1);
    end
    MAxiWready = 1'b1;
    forever begin
      @(negedge clk);
      if ((Occupancy == 0 && !MAxiWvalid) || n > 500) break;
      if (MAxiWvalid) v++; else idle++;
      n++;
    end
    @(posedge clk); #1;
    checks++;
    if (v != 63 || idle != 7 || FramesStored !== '0) begin
      errors++;
      $display("FAIL back_to_back got=v%0d idle%0d f%0d exp=v63 idle7 f0", v, idle, FramesStored);
    end
  endtask

  task automatic test_random();
    int p0 = popCount;
    int total = 0;
    done = 0;
    fork
      begin
        for (int f = 0; f < 250; f++) begin
          int len = $urandom_range(5, 60);
          for (int w = 0; w < len; w++) begin
            while ($urandom_range(0, 1) == 0) begin @(posedge clk); #1; end
            put($urandom, 4'($urandom_range(0, 15)), w == len - 1);
            total++;
          end
        end
        done = 1;
      end
      begin
        while (!done) begin @(posedge clk); #1; MAxiWready = 1'($urandom_range(0, 1)); end
      end
    join
    MAxiWready = 1'b1;
    waitDrain();
    checks++;
    if (popCount - p0 != total || OversizeErr !== 1'b0) begin
      errors++;
      $display("FAIL random_stream got=n%0d e%b exp=n%0d e0", popCount - p0, OversizeErr, total);
    end
  endtask

  task automatic test_saturate();
    MAxiWready = 1'b0;
    for (int i = 0; i < 14; i++) put(32'(i), 4'hF, 1'b1);
    checks++;
    if (FramesStored !== FCW'(14) || OversizeErr !== 1'b0) begin
      errors++;
      $display("FAIL sat_below got=f%0d e%b exp=f14 e0", FramesStored, OversizeErr);
    end
    put(32'hE, 4'hF, 1'b1);
    checks++;
    if (FramesStored !== FCW'(15) || OversizeErr !== 1'b1) begin
      errors++;
      $display("FAIL sat_reach got=f%0d e%b exp=f15 e1", FramesStored, OversizeErr);
    end
    put(32'hF, 4'hF, 1'b1);
    checks++;
    if (FramesStored !== FCW'(15) || Occupancy !== OW'(16)) begin
      errors++;
      $display("FAIL sat_hold got=f%0d o%0d exp=f15 o16", FramesStored, Occupancy);
    end
    applyReset();
  endtask

  task automatic test_oversize();
    int p0 = popCount;
    MAxiWready = 1'b1;
    sawFull = 0;
    for (int i = 0; i < DEPTH + 8; i++) put(32'h5000 + 32'(i), 4'($urandom_range(0, 15)), i == DEPTH + 7);
    waitDrain();
    checks++;
    if (OversizeErr !== 1'b1 || !sawFull || popCount - p0 != DEPTH + 8 || FramesStored !== '0) begin
      errors++;
      $display("FAIL oversize got=e%b full%b n%0d f%0d exp=e1 full1 n%0d f0",
               OversizeErr, sawFull, popCount - p0, FramesStored, DEPTH + 8);
    end
    applyReset();
  endtask

  task automatic test_reset_midframe();
    int p0;
    MAxiWready = 1'b1;
    for (int i = 0; i < 3; i++) put(32'hC0 + 32'(i), 4'hF, 1'b0);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (MAxiWvalid !== 1'b0 || Occupancy !== '0) begin
      errors++;
      $display("FAIL reset_midwrite got=v%b o%0d exp=v0 o0", MAxiWvalid, Occupancy);
    end
    @(posedge clk); #1 resetn = 1'b1;
    sbQ.delete();
    @(posedge clk); #1;
    MAxiWready = 1'b0;
    for (int i = 0; i < 10; i++) put(32'hD0 + 32'(i), 4'hF, i == 9);
    MAxiWready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (MAxiWvalid !== 1'b1) begin errors++; $display("FAIL midread_setup got=%b exp=1", MAxiWvalid); end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (MAxiWvalid !== 1'b0 || Occupancy !== '0 || FramesStored !== '0) begin
      errors++;
      $display("FAIL reset_midread got=v%b o%0d f%0d exp=0", MAxiWvalid, Occupancy, FramesStored);
    end
    @(posedge clk); #1 resetn = 1'b1;
    sbQ.delete();
    @(posedge clk); #1;
    p0 = popCount;
    for (int i = 0; i < 6; i++) put(32'hE0 + 32'(i), 4'h1, i == 5);
    waitDrain();
    checks++;
    if (popCount - p0 != 6 || FramesStored !== '0 || OversizeErr !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_frame got=n%0d f%0d e%b exp=n6 f0 e0", popCount - p0, FramesStored, OversizeErr);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_partial_hold();
    test_fill_full();
    test_random();
    test_saturate();
    test_oversize();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
